core_fetch_unit: RTL
====================

# core_fetch_unit

Parametrised instruction-fetch front end for the xrv32i core. It replaces the fixed-jump, no-hold PC register and instruction-fetch pair with a PC generator, a pipelined ROM request/response interface and an in-order prefetch buffer of configurable depth. Flushes on jump discard in-flight fetches. It feeds core_if_id through a valid/ready handshake.

## Interface
- XLEN, 32: address/instruction width.
- FIFO_DEPTH, 4: prefetch buffer entries.
  - Power of two, ≥2.
- RST_ADDR, `CPURstAddress: PC value after reset.

Clock and reset are fixed: one clock; reset is asynchronous and active-low.

- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- jump_flag_in  in  1  flush and redirect the PC this cycle.
- jump_addr_in  in  XLEN  redirect target.
- rom_req_valid_out  out  1  fetch request valid.
- rom_req_ready_in  in  1  ROM accepts request.
- rom_addr_out  out  XLEN  fetch address.
- rom_rsp_valid_in  in  1  response valid. Responses arrive in request order.
- rom_data_in  in  XLEN  response instruction.
- inst_valid_out  out  1  buffered instruction available.
- inst_ready_in  in  1  consumer takes the instruction. The hold condition is driven as ready low.
- inst_out  out  XLEN  instruction.
- inst_addr_out  out  XLEN  its address.

## Operation
- **Buffer pointers:** the buffer uses three pointers, each log2(FIFO_DEPTH)+1 bits wide:
  - alloc: advances on request handshake and stores rom_addr_out.
  - fill: advances on an accepted response and stores rom_data_in.
  - rd: advances on an inst handshake.
- **Credit:** credit = (alloc−rd) + drop_cnt < FIFO_DEPTH.
- **Request:** rom_req_valid_out = credit & !jump_flag_in.
  - rom_addr_out = pc.
  - On handshake, pc <= pc + 4. The add wraps modulo 2^XLEN.
- **Response:** when drop_cnt≠0, the response is discarded and drop_cnt decrements. Otherwise it fills entry fill.
- **Output:** inst_valid_out = (fill≠rd) & !jump_flag_in. inst_out and inst_addr_out come from entry rd.
- **Jump:** pc <= {jump_addr_in[XLEN-1:2],2'b00}.
  - alloc, fill and rd are all set equal to alloc.
  - drop_cnt <= drop_cnt + (alloc−fill) − (rom_rsp_valid_in ? 1 : 0).
  - A response arriving in the jump cycle is dropped.
  - A pop in the jump cycle does not occur.
  - A jump with no requests in flight sets drop_cnt unchanged.
- **Request-valid stability:** rom_req_valid_out may fall without a handshake only in a jump cycle. The ROM side tolerates this.
- **Simultaneous events:** request, response and pop may all fire in one cycle. Each pointer updates independently.

## Timing
- **Reset values:** rst low asynchronously clears:
  - pc = RST_ADDR
  - all pointers = 0
  - drop_cnt = 0
  - inst_valid_out = 0
  - rom_req_valid_out = 0 while rst is low
  - misaligned-error flag (when compiled in) = 0
- **Reset mid-operation:** all in-flight state is lost. The ROM must drop outstanding responses under the same reset.
- **First request:** rom_req_valid_out asserts in the first cycle after rst deasserts.
- **Latency:** a response accepted in cycle N appears on inst_valid_out in cycle N+1 (registered).
- **Throughput:** one instruction per cycle is sustained when FIFO_DEPTH ≥ ROM latency + 2.
- **Jump:** the first post-jump request is issued in the cycle after jump_flag_in. Its address is the aligned target.
- **Full:** when credit = 0, rom_req_valid_out is low. Pointers hold until a pop.
- **Empty:** inst_valid_out is low. inst_out holds its stale value and is don't-care.

## Configuration
- **FETCH_MISALIGN_CHK_EN defined:** adds port misalign_err_out (out, 1).
  - It is a sticky flag, set in the cycle after a jump with jump_addr_in[1:0]≠0.
  - It is cleared only by reset.
  - The PC is still force-aligned.
- **Not defined:** the port is absent. Low address bits are masked silently.

## Structure
- **defines.v additions:**
  - `FetchDepthDefault (4)
  - `InstAlignMask
- **Reused from defines.v:**
  - `CPURstAddress
  - `InstByteBus
  - `InstAddressBus
- **Sub-module core_fetch_buf:** holds the entry storage (address and data arrays) and the alloc/fill/rd pointer logic.
- **core_fetch_unit:** holds the PC, credit, drop_cnt and jump control.

## Test plan
- **Reset and steady fetch:** reset release with a 1-cycle ROM, always ready, and inst_ready_in=1.
  - Requests go to 0x0, 0x4, 0x8 on consecutive cycles.
  - inst_addr_out shows 0x0 two cycles after the first request, then one instruction per cycle.
- **Backpressure:** inst_ready_in=0 for 10 cycles.
  - Exactly 4 requests are issued, then rom_req_valid_out stays low.
  - On release, instructions 0x0–0xC are delivered in order with none lost.
- **Jump with in-flight requests:** 3-cycle ROM, jump to 0x100 while 2 requests are in flight.
  - Both stale responses are dropped.
  - The next inst_addr_out is 0x100 and the data matches ROM[0x100].
- **Jump coinciding with a response and a pop:** no instruction from the old stream is delivered.
  - drop_cnt returns to 0 after the remaining stale responses.
- **Misaligned jump:** jump to 0x203.
  - Fetch resumes at 0x200.
  - With FETCH_MISALIGN_CHK_EN, misalign_err_out is 1 from the next cycle until reset.
- **Reset mid-stream:** rst asserted while the buffer is full.
  - All outputs show reset values immediately.
  - Fetch restarts at RST_ADDR.

Source files
------------

// File: rtl/core_fetch_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | core_fetch_unit_pkg: shared constants for the xrv32i fetch front end.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package core_fetch_unit_pkg;

  localparam int          FETCH_DEPTH_DEFAULT = 4;
  localparam logic [31:0] CPU_RST_ADDRESS     = 32'h0000_0000;
  localparam int          INST_BYTES          = 4;
  localparam int          INST_ALIGN_BITS     = 2;
  localparam logic [31:0] INST_ALIGN_MASK     = 32'hFFFF_FFFC;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_fetch_buf.sv
// +----------------------------------------------------------------------------+
// | core_fetch_buf: in-order prefetch buffer with alloc/fill/rd pointers.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_fetch_buf
  import core_fetch_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_addr,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop_en,
  output logic [PW-1:0]   occupancy,
  output logic [PW-1:0]   in_flight,
  output logic            not_empty,
  output logic [XLEN-1:0] rd_addr,
  output logic [XLEN-1:0] rd_data
);

  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
    end else if (flush) begin
      // Everything behind alloc is abandoned; stale data is dropped upstream.
      fill_ptr <= alloc_ptr;
      rd_ptr   <= alloc_ptr;
    end else begin
      if (alloc_en) alloc_ptr <= alloc_ptr + PW'(1);
      if (fill_en)  fill_ptr  <= fill_ptr + PW'(1);
      if (pop_en)   rd_ptr    <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en) addr_mem[alloc_ptr[PW-2:0]] <= alloc_addr;
    if (fill_en)  data_mem[fill_ptr[PW-2:0]]  <= fill_data;
  end

  assign occupancy = alloc_ptr - rd_ptr;
  assign in_flight = alloc_ptr - fill_ptr;
  assign not_empty = (fill_ptr != rd_ptr);
  assign rd_addr   = addr_mem[rd_ptr[PW-2:0]];
  assign rd_data   = data_mem[rd_ptr[PW-2:0]];

endmodule

`default_nettype wire

// File: rtl/core_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | core_fetch_unit: PC generator, credit/drop control and jump flush.          |
// | Optional FETCH_MISALIGN_CHK_EN adds sticky misalign_err_out. Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_fetch_unit
  import core_fetch_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = FETCH_DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RST_ADDR   = XLEN'(CPU_RST_ADDRESS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_flag_in,
  input  logic [XLEN-1:0] jump_addr_in,
  output logic            rom_req_valid_out,
  input  logic            rom_req_ready_in,
  output logic [XLEN-1:0] rom_addr_out,
  input  logic            rom_rsp_valid_in,
  input  logic [XLEN-1:0] rom_data_in,
  output logic            inst_valid_out,
  input  logic            inst_ready_in,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_addr_out
`ifdef FETCH_MISALIGN_CHK_EN
  ,output logic           misalign_err_out
`endif
);

  localparam int PW = ptr_width(FIFO_DEPTH);

  logic [XLEN-1:0] pc;
  logic [PW-1:0]   drop_cnt;
  logic [PW-1:0]   occupancy;
  logic [PW-1:0]   in_flight;
  logic [PW:0]     used;
  logic            buf_not_empty;
  logic            credit;
  logic            req_fire;
  logic            rsp_fill;
  logic            pop_fire;

  // Stale responses still owed by the ROM consume credit like live entries.
  assign used              = {1'b0, occupancy} + {1'b0, drop_cnt};
  assign credit            = (used < (PW+1)'(FIFO_DEPTH));
  assign rom_req_valid_out = rst & credit & ~jump_flag_in;
  assign rom_addr_out      = pc;
  assign req_fire          = rom_req_valid_out & rom_req_ready_in;
  assign rsp_fill          = rom_rsp_valid_in & ~jump_flag_in & (drop_cnt == '0);
  assign inst_valid_out    = buf_not_empty & ~jump_flag_in;
  assign pop_fire          = inst_valid_out & inst_ready_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RST_ADDR;
      drop_cnt <= '0;
    end else if (jump_flag_in) begin
      pc       <= {jump_addr_in[XLEN-1:INST_ALIGN_BITS], {INST_ALIGN_BITS{1'b0}}};
      drop_cnt <= drop_cnt + in_flight - PW'(rom_rsp_valid_in);
    end else begin
      if (req_fire) pc <= pc + XLEN'(INST_BYTES);
      if (rom_rsp_valid_in && drop_cnt != '0) drop_cnt <= drop_cnt - PW'(1);
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_err_out <= 1'b0;
    else if (jump_flag_in && |jump_addr_in[INST_ALIGN_BITS-1:0]) misalign_err_out <= 1'b1;
  end
`else
  logic unused_align_bits;
  assign unused_align_bits = |jump_addr_in[INST_ALIGN_BITS-1:0];
`endif

  core_fetch_buf #(
    .XLEN  (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (jump_flag_in),
    .alloc_en   (req_fire),
    .alloc_addr (rom_addr_out),
    .fill_en    (rsp_fill),
    .fill_data  (rom_data_in),
    .pop_en     (pop_fire),
    .occupancy  (occupancy),
    .in_flight  (in_flight),
    .not_empty  (buf_not_empty),
    .rd_addr    (inst_addr_out),
    .rd_data    (inst_out)
  );

endmodule

`default_nettype wire
